// File: rtl/iob_cache_wtb_merge.sv
// Write-through buffer between the cache front end and the memory back end.
// Writes to the youngest entry's address are coalesced. The head entry is never merged into.
module iob_cache_wtb_merge #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int DEPTH_W  = 2,
    parameter int MERGE_EN = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  w_avalid_i,
    input  logic [ADDR_W-1:0]     w_addr_i,
    input  logic [DATA_W-1:0]     w_wdata_i,
    input  logic [DATA_W/8-1:0]   w_wstrb_i,
    output logic                  w_ready_o,
    input  logic [ADDR_W-1:0]     chk_addr_i,
    output logic                  chk_hit_o,
    output logic                  be_avalid_o,
    output logic [ADDR_W-1:0]     be_addr_o,
    output logic [DATA_W-1:0]     be_wdata_o,
    output logic [DATA_W/8-1:0]   be_wstrb_o,
    input  logic                  be_ready_i,
    output logic [DEPTH_W:0]      level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [15:0]           merge_cnt_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 2 ** DEPTH_W;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [NBYTES-1:0] mem_strb [DEPTH];

    logic [DEPTH_W-1:0] head;
    logic [DEPTH_W-1:0] tail;
    logic [DEPTH_W-1:0] young;
    logic [DEPTH_W-1:0] off;
    logic [DEPTH_W:0]   level;
    logic [15:0]        merge_cnt;

    logic wr_any;
    logic merge_ok;
    logic full;
    logic empty;
    logic do_push;
    logic do_merge;
    logic do_pop;

    assign young  = tail - DEPTH_W'(1);
    assign wr_any = |w_wstrb_i;
    assign full   = (level == (DEPTH_W+1)'(DEPTH));
    assign empty  = (level == '0);

    // level >= 2 guarantees the youngest entry is not the head
    assign merge_ok = (MERGE_EN != 0)
                    && (level >= (DEPTH_W+1)'(2))
                    && (mem_addr[young] == w_addr_i);

    assign do_merge = w_avalid_i & wr_any & merge_ok;
    assign do_push  = w_avalid_i & wr_any & ~merge_ok & ~full;
    assign do_pop   = ~empty & be_ready_i;

    assign w_ready_o   = ~full | merge_ok | ~wr_any;
    assign be_avalid_o = ~empty;
    assign be_addr_o   = mem_addr[head];
    assign be_wdata_o  = mem_data[head];
    assign be_wstrb_o  = mem_strb[head];
    assign level_o     = level;
    assign empty_o     = empty;
    assign full_o      = full;
    assign merge_cnt_o = merge_cnt;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            head      <= '0;
            tail      <= '0;
            level     <= '0;
            merge_cnt <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + DEPTH_W'(1);
            end
            if (do_pop) begin
                head <= head + DEPTH_W'(1);
            end
            level <= level + (DEPTH_W+1)'(do_push) - (DEPTH_W+1)'(do_pop);
            if (do_merge && merge_cnt != 16'hFFFF) begin
                merge_cnt <= merge_cnt + 16'd1;
            end
        end
    end

    // Entry storage needs no reset; validity comes from head/level
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_addr[tail] <= w_addr_i;
            mem_data[tail] <= w_wdata_i;
            mem_strb[tail] <= w_wstrb_i;
        end else if (do_merge) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_wstrb_i[b]) begin
                    mem_data[young][8*b +: 8] <= w_wdata_i[8*b +: 8];
                end
            end
            mem_strb[young] <= mem_strb[young] | w_wstrb_i;
        end
    end

    always_comb begin
        chk_hit_o = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = DEPTH_W'(i) - head;
            if (({1'b0, off} < level) && (mem_addr[i] == chk_addr_i)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_cache_wtb_merge.sv
// Randomised and directed bench for iob_cache_wtb_merge.
// A queue-based model supplies the expected buffer contents.
module tb_iob_cache_wtb_merge;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        w_avalid;
    logic [23:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [23:0] chk_addr;
    logic        be_ready;

    logic        w_ready, chk_hit, be_avalid, empty, full;
    logic [23:0] be_addr;
    logic [31:0] be_data;
    logic [3:0]  be_strb;
    logic [2:0]  level;
    logic [15:0] merge_cnt;

    logic        w_ready_nm, chk_hit_nm, be_avalid_nm, empty_nm, full_nm;
    logic [23:0] be_addr_nm;
    logic [31:0] be_data_nm;
    logic [3:0]  be_strb_nm;
    logic [2:0]  level_nm;
    logic [15:0] merge_cnt_nm;

    int n_cmp = 0;
    int n_err = 0;

    ent_t q[$];
    int unsigned m_merges;

    iob_cache_wtb_merge #(.ADDR_W(24), .DATA_W(32), .DEPTH_W(2), .MERGE_EN(1)) dut (
        .clk_i(clk), .arst_i(rst_n),
        .w_avalid_i(w_avalid), .w_addr_i(w_addr), .w_wdata_i(w_data),
        .w_wstrb_i(w_strb), .w_ready_o(w_ready),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit),
        .be_avalid_o(be_avalid), .be_addr_o(be_addr), .be_wdata_o(be_data),
        .be_wstrb_o(be_strb), .be_ready_i(be_ready),
        .level_o(level), .empty_o(empty), .full_o(full),
        .merge_cnt_o(merge_cnt)
    );

    iob_cache_wtb_merge #(.ADDR_W(24), .DATA_W(32), .DEPTH_W(2), .MERGE_EN(0)) dut_nm (
        .clk_i(clk), .arst_i(rst_n),
        .w_avalid_i(w_avalid), .w_addr_i(w_addr), .w_wdata_i(w_data),
        .w_wstrb_i(w_strb), .w_ready_o(w_ready_nm),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit_nm),
        .be_avalid_o(be_avalid_nm), .be_addr_o(be_addr_nm), .be_wdata_o(be_data_nm),
        .be_wstrb_o(be_strb_nm), .be_ready_i(be_ready),
        .level_o(level_nm), .empty_o(empty_nm), .full_o(full_nm),
        .merge_cnt_o(merge_cnt_nm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_merge();
        return q.size() >= 2 && q[$].addr == w_addr;
    endfunction

    function automatic bit m_ready();
        return q.size() < 4 || m_merge() || w_strb == 4'h0;
    endfunction

    function automatic bit m_hit(input logic [23:0] a);
        foreach (q[i]) if (q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock and apply the buffer rules to the model.
    task automatic cycle();
        bit dm, dp, dq;
        ent_t e;
        dm = w_avalid && w_strb != 4'h0 && m_merge();
        dp = w_avalid && w_strb != 4'h0 && !dm && q.size() < 4;
        dq = q.size() > 0 && be_ready;
        @(posedge clk);
        if (rst_n) begin
            if (dm) begin
                e = q[$];
                for (int b = 0; b < 4; b++)
                    if (w_strb[b]) e.data[8*b +: 8] = w_data[8*b +: 8];
                e.strb = e.strb | w_strb;
                q[$] = e;
                if (m_merges < 65535) m_merges++;
            end
            if (dp) begin
                e.addr = w_addr; e.data = w_data; e.strb = w_strb;
                q.push_back(e);
            end
            if (dq) void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic idle();
        w_avalid = 1'b0; w_strb = 4'h0; be_ready = 1'b0;
    endtask

    task automatic push(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
        w_avalid = 1'b1; w_addr = a; w_data = d; w_strb = s;
        cycle();
        w_avalid = 1'b0; w_strb = 4'h0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        q.delete(); m_merges = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
        n_cmp++; if (be_avalid !== 1'b0) begin n_err++; $display("FAIL rst_be_avalid: got %b want 0", be_avalid); end
        n_cmp++; if (chk_hit !== 1'b0) begin n_err++; $display("FAIL rst_chk_hit: got %b want 0", chk_hit); end
        n_cmp++; if (merge_cnt !== 16'd0) begin n_err++; $display("FAIL rst_merge_cnt: got %0d want 0", merge_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        w_avalid = 1'b1; w_strb = 4'hF; w_addr = 24'h1;
        #1;
        n_cmp++; if (w_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", w_ready); end
        idle();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) push(24'h10 + 24'(i), $urandom, 4'hF);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d want 4", level); end
        w_avalid = 1'b1; w_addr = 24'h14; w_data = 32'h1; w_strb = 4'hF;
        #1;
        n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL fill_5th_ready: got %b want 0", w_ready); end
        be_ready = 1'b1;
        #1;
        n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL fill_pop_ready: got %b want 0", w_ready); end
        cycle();
        idle();
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL fill_stall_level: got %0d want 3", level); end
    endtask

    task automatic test_merge();
        do_reset();
        push(24'h20, 32'h0000AAAA, 4'b0011);
        push(24'h40, 32'h0000BBBB, 4'b0011);
        push(24'h40, 32'hCCCC0000, 4'b1100);
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL merge_level: got %0d want 2", level); end
        n_cmp++; if (merge_cnt !== 16'd1) begin n_err++; $display("FAIL merge_cnt: got %0d want 1", merge_cnt); end
        n_cmp++; if (level_nm !== 3'd3) begin n_err++; $display("FAIL nomerge_level: got %0d want 3", level_nm); end
        n_cmp++; if (merge_cnt_nm !== 16'd0) begin n_err++; $display("FAIL nomerge_cnt: got %0d want 0", merge_cnt_nm); end
        n_cmp++; if (be_addr !== 24'h20) begin n_err++; $display("FAIL merge_head_addr: got %0h want 20", be_addr); end
        be_ready = 1'b1;
        push(24'h40, 32'h000000DD, 4'b0001);
        be_ready = 1'b0;
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL merge_pop_level: got %0d want 1", level); end
        n_cmp++; if (be_addr !== 24'h40) begin n_err++; $display("FAIL merge_pop_addr: got %0h want 40", be_addr); end
        n_cmp++; if (be_data !== 32'hCCCCBBDD) begin n_err++; $display("FAIL merge_data: got %0h want ccccbbdd", be_data); end
        n_cmp++; if (be_strb !== 4'hF) begin n_err++; $display("FAIL merge_strb: got %0h want f", be_strb); end
        n_cmp++; if (merge_cnt !== 16'd2) begin n_err++; $display("FAIL merge_cnt2: got %0d want 2", merge_cnt); end
    endtask

    task automatic test_no_head_merge();
        logic [31:0] d1;
        d1 = $urandom;
        do_reset();
        push(24'h30, d1, 4'hF);
        push(24'h30, ~d1, 4'hF);
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL nohead_level: got %0d want 2", level); end
        n_cmp++; if (be_addr !== 24'h30) begin n_err++; $display("FAIL nohead_addr: got %0h want 30", be_addr); end
        n_cmp++; if (be_data !== d1) begin n_err++; $display("FAIL nohead_data: got %0h want %0h", be_data, d1); end
        n_cmp++; if (merge_cnt !== 16'd0) begin n_err++; $display("FAIL nohead_cnt: got %0d want 0", merge_cnt); end
    endtask

    task automatic test_wrap();
        ent_t exp[$];
        ent_t e;
        int pushed, budget;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e.addr = 24'h200 + 24'(i); e.data = $urandom; e.strb = 4'hF;
            exp.push_back(e);
            push(e.addr, e.data, e.strb);
        end
        be_ready = 1'b1;
        pushed = 0;
        budget = 0;
        while ((pushed < 10 || exp.size() > 0) && budget < 60) begin
            if (pushed < 10) begin
                w_avalid = 1'b1; w_addr = 24'h204 + 24'(pushed);
                w_data = 32'hD000 + 32'(pushed); w_strb = 4'hF;
            end else begin
                w_avalid = 1'b0; w_strb = 4'h0;
            end
            #1;
            n_cmp++; if (level > 3'd4) begin n_err++; $display("FAIL wrap_level: got %0d want <=4", level); end
            if (be_avalid) begin
                e = exp.pop_front();
                n_cmp++;
                if (be_addr !== e.addr || be_data !== e.data) begin
                    n_err++; $display("FAIL wrap_order: got %0h/%0h want %0h/%0h", be_addr, be_data, e.addr, e.data);
                end
            end
            if (pushed < 10 && w_ready) begin
                e.addr = w_addr; e.data = w_data; e.strb = w_strb;
                exp.push_back(e);
                pushed++;
            end
            cycle();
            budget++;
        end
        n_cmp++; if (budget >= 60) begin n_err++; $display("FAIL wrap_timeout: got %0d left want 0", exp.size()); end
        idle();
    endtask

    task automatic test_hazard();
        do_reset();
        chk_addr = 24'h55;
        w_avalid = 1'b1; w_addr = 24'h55; w_data = 32'h5555; w_strb = 4'hF;
        #1;
        n_cmp++; if (chk_hit !== 1'b0) begin n_err++; $display("FAIL hz_same_cycle: got %b want 0", chk_hit); end
        n_cmp++; if (be_avalid !== 1'b0) begin n_err++; $display("FAIL hz_bypass: got %b want 0", be_avalid); end
        cycle();
        idle();
        #1;
        n_cmp++; if (chk_hit !== 1'b1) begin n_err++; $display("FAIL hz_hit: got %b want 1", chk_hit); end
        n_cmp++; if (be_avalid !== 1'b1) begin n_err++; $display("FAIL hz_visible: got %b want 1", be_avalid); end
        be_ready = 1'b1;
        cycle();
        idle();
        #1;
        n_cmp++; if (chk_hit !== 1'b0) begin n_err++; $display("FAIL hz_after_pop: got %b want 0", chk_hit); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) push(24'h70 + 24'(i), $urandom, 4'hF);
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL rmid_pre_level: got %0d want 3", level); end
        #2;
        rst_n = 1'b0;
        q.delete(); m_merges = 0;
        #1;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rmid_level: got %0d want 0", level); end
        n_cmp++; if (be_avalid !== 1'b0) begin n_err++; $display("FAIL rmid_be_avalid: got %b want 0", be_avalid); end
        @(negedge clk);
        rst_n = 1'b1;
        w_avalid = 1'b1; w_addr = 24'h70; w_strb = 4'hF;
        #1;
        n_cmp++; if (w_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", w_ready); end
        idle();
        #1;
    endtask

    task automatic test_random();
        bit exp_ready;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            w_avalid = ($urandom_range(0, 9) < 7);
            w_addr   = 24'h100 + 24'($urandom_range(0, 3));
            w_data   = $urandom;
            w_strb   = 4'($urandom_range(0, 15));
            be_ready = ($urandom_range(0, 1) == 1);
            chk_addr = 24'h100 + 24'($urandom_range(0, 3));
            #1;
            exp_ready = m_ready();
            n_cmp++; if (w_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", n, w_ready, exp_ready); end
            n_cmp++; if (level !== 3'(q.size())) begin n_err++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, level, q.size()); end
            n_cmp++; if (full !== (q.size() == 4)) begin n_err++; $display("FAIL rnd_full@%0d: got %b", n, full); end
            n_cmp++; if (empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty@%0d: got %b", n, empty); end
            n_cmp++; if (merge_cnt !== 16'(m_merges)) begin n_err++; $display("FAIL rnd_mcnt@%0d: got %0d want %0d", n, merge_cnt, m_merges); end
            n_cmp++; if (chk_hit !== m_hit(chk_addr)) begin n_err++; $display("FAIL rnd_hit@%0d: got %b", n, chk_hit); end
            if (q.size() > 0) begin
                n_cmp++;
                if (be_addr !== q[0].addr || be_data !== q[0].data || be_strb !== q[0].strb) begin
                    n_err++;
                    $display("FAIL rnd_head@%0d: got %0h/%0h/%0h want %0h/%0h/%0h", n,
                             be_addr, be_data, be_strb, q[0].addr, q[0].data, q[0].strb);
                end
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        w_avalid = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
        chk_addr = '0; be_ready = 1'b0;
        m_merges = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_fill();
        test_merge();
        test_no_head_merge();
        test_wrap();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
